// File: rtl/rv_instr_encoder_if.sv
`default_nettype none
// ------------------------------------------------------------------
// rv_instr_encoder_if : field-bundle in / encoded-word out streams. Rev 1.0
// ------------------------------------------------------------------
interface rv_instr_encoder_if #(
  parameter int ADDR_W = 14
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, opcode, funct3, rd, rs1, rs2, funct7, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, opcode, funct3, rd, rs1, rs2, funct7, imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface
`default_nettype wire

// File: rtl/rv_instr_encoder.sv
`default_nettype none
// ------------------------------------------------------------------
// rv_instr_encoder : RV32I field packer with word FIFO and IMEM address. Rev 1.0
// ------------------------------------------------------------------
module rv_instr_encoder #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 14,
  parameter int BASE_ADDR = 0
) (
  input  wire                clk,
  input  wire                rst,
  rv_instr_encoder_if.slave  bus,
  input  wire                addr_load,
  input  wire [ADDR_W-1:0]   addr_load_val,
  output logic               err,
  input  wire                err_clr
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_csr    = 7'b1110011;

  localparam logic [AW:0]       c_ptr_one  = 1;
  localparam logic [ADDR_W-1:0] c_addr_one = 1;
  localparam logic [ADDR_W-1:0] c_base     = ADDR_W'(BASE_ADDR);

  logic [31:0] w_imm;
  logic [6:0]  w_opc;
  logic [31:0] w_word;
  logic        w_legal;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  logic [31:0]       r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;

  assign w_imm = bus.imm;
  assign w_opc = bus.opcode;

  // Each immediate must equal its encoded field sign-extended back to 32 bits.
  always_comb begin
    w_word  = '0;
    w_legal = 1'b0;
    case (w_opc)
      c_op_lui, c_op_auipc: begin
        w_word  = {w_imm[31:12], bus.rd, w_opc};
        w_legal = (w_imm[11:0] == 12'h000);
      end
      c_op_jal: begin
        w_word  = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.rd, w_opc};
        w_legal = !w_imm[0] && (w_imm[31:21] == {11{w_imm[20]}});
      end
      c_op_branch: begin
        w_word  = {w_imm[12], w_imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                   w_imm[4:1], w_imm[11], w_opc};
        w_legal = !w_imm[0] && (w_imm[31:13] == {19{w_imm[12]}});
      end
      c_op_store: begin
        w_word  = {w_imm[11:5], bus.rs2, bus.rs1, bus.funct3, w_imm[4:0], w_opc};
        w_legal = (w_imm[31:12] == {20{w_imm[11]}});
      end
      c_op_jalr, c_op_load: begin
        w_word  = {w_imm[11:0], bus.rs1, bus.funct3, bus.rd, w_opc};
        w_legal = (w_imm[31:12] == {20{w_imm[11]}});
      end
      c_op_itype: begin
        if (bus.funct3[1:0] == 2'b01) begin
          w_word  = {bus.funct7, w_imm[4:0], bus.rs1, bus.funct3, bus.rd, w_opc};
          w_legal = (w_imm[31:5] == 27'h0);
        end else begin
          w_word  = {w_imm[11:0], bus.rs1, bus.funct3, bus.rd, w_opc};
          w_legal = (w_imm[31:12] == {20{w_imm[11]}});
        end
      end
      c_op_rtype: begin
        w_word  = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, w_opc};
        w_legal = 1'b1;
      end
      c_op_csr: begin
        if (bus.funct3[2]) begin
          w_word  = {bus.funct7, bus.rs2, w_imm[4:0], bus.funct3, bus.rd, w_opc};
          w_legal = (w_imm[31:5] == 27'h0);
        end else begin
          w_word  = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, w_opc};
          w_legal = 1'b1;
        end
      end
      default: begin
        w_word  = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // Illegal bundles still complete the handshake; they just never reach the FIFO.
  assign w_accept = bus.in_valid && !w_full;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = !w_empty && bus.out_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_addr <= c_base;
      r_err  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      if (addr_load) begin
        r_addr <= addr_load_val;
      end else if (w_pop) begin
        r_addr <= r_addr + c_addr_one;
      end
      if (w_accept && !w_legal) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.out_valid = !w_empty;
  assign bus.out_instr = w_empty ? 32'h0 : r_mem[r_rptr[AW-1:0]];
  assign bus.out_addr  = r_addr;
  assign err           = r_err;

endmodule
`default_nettype wire

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
- Inverse of the instruction-field decoder. Accepts RV32I instruction fields (opcode, funct3, rd, rs1, rs2, funct7, sign-extended imm) on a valid/ready stream.
- Packs the fields into 32-bit instruction words and checks that each immediate is encodable in its format.
- Buffers encoded words in a small FIFO and emits them with an auto-incrementing IMEM word address.
- Sits between the program loader / test generator and the IMEM write port.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- ADDR_W, 14, width of the IMEM word address.
- BASE_ADDR, 0, address counter value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- opcode  in  7  RV32I opcode (Opcode.vh values).
- funct3  in  3  funct3.
- rd, rs1, rs2  in  5 each  register indices.
- funct7  in  7  funct7; for CSR, the CSR address is {funct7, rs2}.
- imm  in  32  sign-extended immediate, as the decoder produces it.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_instr  out  32  encoded word at the FIFO head.
- out_addr  out  ADDR_W  IMEM word address for the head.
- addr_load  in  1  load the address counter.
- addr_load_val  in  ADDR_W  value for addr_load.
- err  out  1  sticky illegal-bundle flag.
- err_clr  in  1  clear err.

Behaviour:
- Reset: async, takes effect immediately.
  - FIFO is emptied; out_valid=0, out_instr=0.
  - out_addr=BASE_ADDR, err=0.
  - in_ready=1 once rst deasserts.
- Accept: in_valid & in_ready at a rising edge.
  - Encoding is combinational from the inputs; the word is written to the FIFO tail at that edge.
  - Latency: out_valid=1 the cycle after accept when the FIFO was empty.
- in_ready = !full. It does not depend on out_ready, so there is no push into a full FIFO even if a pop occurs in the same cycle.
- Pop: out_valid & out_ready. Head advances and the address counter increments, wrapping mod 2^ADDR_W.
- Simultaneous push and pop on a non-full FIFO: both happen; occupancy is unchanged.
- Ordering: FIFO order is strictly preserved. out_instr and out_addr are stable while out_valid & !out_ready.
- addr_load: counter <= addr_load_val at the next edge and overrides a simultaneous pop increment. The FIFO contents are not flushed.
- Encodings. Imm must equal its field sign-extended to 32 bits, else the bundle is illegal.
  - LUI/AUIPC: {imm[31:12], rd, opc}. Illegal if imm[11:0]!=0.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc}. Illegal if imm[0]=1 or imm[31:21]!={11{imm[20]}}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opc}. Illegal if imm[0]=1 or imm[31:13]!={19{imm[12]}}.
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], opc}. Illegal if imm[31:12]!={20{imm[11]}}.
  - JALR/LOAD/ARI_ITYPE: {imm[11:0], rs1, funct3, rd, opc}. Same range rule as STORE.
    - Exception, ARI_ITYPE with funct3=001/101: {funct7, imm[4:0], rs1, funct3, rd, opc}. Illegal if imm[31:5]!=0.
  - ARI_RTYPE: {funct7, rs2, rs1, funct3, rd, opc}. Imm ignored.
  - CSR: {funct7, rs2, rs1f, funct3, rd, opc}.
    - rs1f = imm[4:0] if funct3[2]=1; illegal if imm[31:5]!=0.
    - Otherwise rs1f = rs1.
  - Any other opcode: illegal.
- Illegal bundle:
  - It is consumed (handshake completes) but not written to the FIFO.
  - err is set at that edge; address and occupancy are unchanged.
- err clear: err_clr clears err at the next edge. A new illegal accept in the same cycle wins, so err stays 1.

Test Plan:
1. ADDI x1,x0,5 (opc 0010011, f3 0, rd 1, imm 5), out_ready=1 -> next cycle out_valid=1, out_instr=0x00500093, out_addr=0. After the pop, out_addr=1.
2. BEQ x1,x2 imm=0xFFFFFFFC -> 0xFE208EE3. JAL x1 imm=0x800 -> 0x001000EF. LUI x5 imm=0x12345000 -> 0x123452B7. All three in back-to-back cycles, emitted at consecutive addresses.
3. BRANCH imm=3, then STORE imm=0x800 -> both consumed, no out_valid, err=1, out_addr unchanged. err_clr asserted alone -> err=0 next cycle.
4. out_ready=0 and five legal bundles pushed (DEPTH=4) -> in_ready=0 after four accepts. Raise out_ready -> the 4 words drain in order at addr 0..3, then the fifth is accepted and emitted at addr 4.
5. addr_load_val=0x3FFF asserted together with a pop -> out_addr=0x3FFF. Next pop -> out_addr=0x0000 (wrap).
6. Assert rst between edges with 3 entries queued -> out_valid=0, out_addr=BASE_ADDR, err=0 immediately. After release, first legal push appears at BASE_ADDR.
